vga_controller: RTL and testbench



---
 rtl/vga_pkg.sv | 54 +++++
 rtl/vga_if.sv | 27 ++
 rtl/vga_sync_gen.sv | 62 ++++++
 rtl/vga_controller.sv | 81 ++++++++
 tb/tb_vga_controller.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz) and the colour-bar lookup table.
package vga_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_BAR_WIDTH = 80;

  localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef enum logic [2:0] {
    BarWhite,
    BarYellow,
    BarCyan,
    BarGreen,
    BarMagenta,
    BarRed,
    BarBlue,
    BarBlack
  } bar_e;

  // Packed as {red, green, blue}.
  localparam logic [23:0] COLOR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COLOR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COLOR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COLOR_GREEN   = 24'h00FF00;
  localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COLOR_RED     = 24'hFF0000;
  localparam logic [23:0] COLOR_BLUE    = 24'h0000FF;
  localparam logic [23:0] COLOR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(bar_e bar);
    logic [23:0] color;
    color = COLOR_BLACK;
    unique case (bar)
      BarWhite:   color = COLOR_WHITE;
      BarYellow:  color = COLOR_YELLOW;
      BarCyan:    color = COLOR_CYAN;
      BarGreen:   color = COLOR_GREEN;
      BarMagenta: color = COLOR_MAGENTA;
      BarRed:     color = COLOR_RED;
      BarBlue:    color = COLOR_BLUE;
      BarBlack:   color = COLOR_BLACK;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/vga_if.sv
// Bundle of the signals that leave the controller towards the board's VGA DAC pins.
interface vga_if;
  logic       blank_n;
  logic       HS;
  logic       VS;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;

  modport master (
    output blank_n,
    output HS,
    output VS,
    output red,
    output green,
    output blue
  );

  modport slave (
    input blank_n,
    input HS,
    input VS,
    input red,
    input green,
    input blue
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Horizontal/vertical pixel counters and the combinational active/HS/VS decode.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  localparam int unsigned HTot     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned VTot     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned HW       = $clog2(HTot),
  localparam int unsigned VW       = $clog2(VTot)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [HW-1:0] o_h_cnt,
  output logic          o_active,
  output logic          o_hs,
  output logic          o_vs
);

  localparam logic [HW-1:0] HLast      = HW'(HTot - 1);
  localparam logic [HW-1:0] HActEnd    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HSyncStart = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HSyncEnd   = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] VLast      = VW'(VTot - 1);
  localparam logic [VW-1:0] VActEnd    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VSyncStart = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VSyncEnd   = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == HLast) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == VLast) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  logic w_h_sync_win;
  logic w_v_sync_win;

  always_comb begin
    w_h_sync_win = (r_h_cnt >= HSyncStart) && (r_h_cnt <= HSyncEnd);
    w_v_sync_win = (r_v_cnt >= VSyncStart) && (r_v_cnt <= VSyncEnd);
    o_active     = (r_h_cnt < HActEnd) && (r_v_cnt < VActEnd);
    o_hs         = ~w_h_sync_win;
    o_vs         = ~w_v_sync_win;
    o_h_cnt      = r_h_cnt;
  end

endmodule

// File: rtl/vga_controller.sv
// VGA timing generator with an 8-bar vertical colour test pattern; every pin is registered
// so HS, VS, blank_n and RGB stay mutually aligned one clock behind the counters.
module vga_controller
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter int unsigned BAR_WIDTH = DEF_BAR_WIDTH
) (
  input  logic  vga_clk,
  input  logic  reset,
  vga_if.master vga
);

  localparam int unsigned HW = $clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [HW-1:0] BarW = HW'(BAR_WIDTH);

  logic [HW-1:0] w_h_cnt;
  logic          w_active;
  logic          w_hs;
  logic          w_vs;
  logic [2:0]    w_bar;
  logic [23:0]   w_rgb;

  vga_sync_gen #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_sync (
    .i_clk    (vga_clk),
    .i_rst    (reset),
    .o_h_cnt  (w_h_cnt),
    .o_active (w_active),
    .o_hs     (w_hs),
    .o_vs     (w_vs)
  );

  // Bar index is only meaningful inside the active region, where it is always 0..7.
  always_comb begin
    w_bar = 3'(w_h_cnt / BarW);
    w_rgb = w_active ? bar_color(bar_e'(w_bar)) : 24'h000000;
  end

  logic        r_blank_n;
  logic        r_hs;
  logic        r_vs;
  logic [23:0] r_rgb;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_blank_n <= 1'b0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_rgb     <= '0;
    end else begin
      r_blank_n <= w_active;
      r_hs      <= w_hs;
      r_vs      <= w_vs;
      r_rgb     <= w_rgb;
    end
  end

  assign vga.blank_n = r_blank_n;
  assign vga.HS      = r_hs;
  assign vga.VS      = r_vs;
  assign vga.red     = r_rgb[23:16];
  assign vga.green   = r_rgb[15:8];
  assign vga.blue    = r_rgb[7:0];

endmodule

// File: tb/tb_vga_controller.sv
// Bench: default-timing DUT for line timing, pattern and async reset; a shrunken-timing DUT
// for whole-frame behaviour over three frames.
module tb_vga_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1;
  logic rst_s = 1'b1;

  vga_if if_d ();
  vga_if if_s ();

  vga_controller dut (
    .vga_clk (clk),
    .reset   (rst_d),
    .vga     (if_d)
  );

  // Small frame: 24 clocks per line, 12 lines per frame, 2-pixel bars.
  vga_controller #(
    .H_VISIBLE (16),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_BACK    (3),
    .V_VISIBLE (6),
    .V_FRONT   (2),
    .V_SYNC    (2),
    .V_BACK    (2),
    .BAR_WIDTH (2)
  ) dut_s (
    .vga_clk (clk),
    .reset   (rst_s),
    .vga     (if_s)
  );

  typedef struct {
    string       name;
    int          edge_n;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[$];
  logic [23:0] colors [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int tests  = 0;
  int failed = 0;

  int   e;
  int   hs_low;
  int   hs_fall;
  int   blank_fall;
  logic prev_hs;
  logic prev_blank;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(string name, int edge_n, logic hs, logic vs, logic blank,
                              logic [23:0] rgb);
    vec_t v;
    v.name = name; v.edge_n = edge_n; v.hs = hs; v.vs = vs; v.blank = blank; v.rgb = rgb;
    return v;
  endfunction

  function automatic logic [23:0] rgb_d();
    return {if_d.red, if_d.green, if_d.blue};
  endfunction

  task automatic clear_track();
    e = 0; hs_low = 0; hs_fall = 0; blank_fall = 0; prev_hs = 1'b1; prev_blank = 1'b0;
  endtask

  // One output edge of the default DUT, sampled 1 ns after the rising edge.
  task automatic step_d();
    @(posedge clk);
    #1;
    e++;
    if (!if_d.HS) hs_low++;
    if (prev_hs && !if_d.HS && hs_fall == 0) hs_fall = e;
    if (prev_blank && !if_d.blank_n && blank_fall == 0) blank_fall = e;
    prev_hs    = if_d.HS;
    prev_blank = if_d.blank_n;
  endtask

  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      while (e < vecs[i].edge_n) step_d();
      check({tag, ".", vecs[i].name, ".hs"},    32'(if_d.HS),      32'(vecs[i].hs));
      check({tag, ".", vecs[i].name, ".vs"},    32'(if_d.VS),      32'(vecs[i].vs));
      check({tag, ".", vecs[i].name, ".blank"}, 32'(if_d.blank_n), 32'(vecs[i].blank));
      check({tag, ".", vecs[i].name, ".rgb"},   32'(rgb_d()),      32'(vecs[i].rgb));
    end
    check({tag, ".hs_low_width"}, hs_low,     96);
    check({tag, ".hs_fall_edge"}, hs_fall,    657);
    check({tag, ".blank_fall"},   blank_fall, 641);
  endtask

  task automatic run_small();
    int mism, vs_low, bad_hs_per, hs_falls, blank_vert, max_h, max_v, last_hs_fall;
    int vs_fall[$];
    logic p_hs, p_vs;
    mism = 0; vs_low = 0; bad_hs_per = 0; hs_falls = 0; blank_vert = 0;
    max_h = 0; max_v = 0; last_hs_fall = 0; p_hs = 1'b1; p_vs = 1'b1;
    check("small.rst.hs",    32'(if_s.HS),      32'd1);
    check("small.rst.vs",    32'(if_s.VS),      32'd1);
    check("small.rst.blank", 32'(if_s.blank_n), 32'd0);
    @(negedge clk);
    rst_s = 1'b0;
    for (int n = 1; n <= 864; n++) begin
      int h, ln;
      logic xb, xh, xv;
      logic [23:0] xr;
      @(posedge clk);
      #1;
      h  = (n - 1) % 24;
      ln = ((n - 1) / 24) % 12;
      xb = (h < 16) && (ln < 6);
      xh = !(h >= 18 && h <= 20);
      xv = !(ln >= 8 && ln <= 9);
      xr = xb ? colors[h / 2] : 24'h0;
      if (if_s.blank_n !== xb || if_s.HS !== xh || if_s.VS !== xv ||
          {if_s.red, if_s.green, if_s.blue} !== xr) begin
        if (mism == 0)
          $display("FAIL small.first_diff at edge %0d: blank=%b hs=%b vs=%b rgb=%h required %b %b %b %h",
                   n, if_s.blank_n, if_s.HS, if_s.VS, {if_s.red, if_s.green, if_s.blue},
                   xb, xh, xv, xr);
        mism++;
      end
      if (!if_s.VS) vs_low++;
      if (p_vs && !if_s.VS) vs_fall.push_back(n);
      if (p_hs && !if_s.HS) begin
        if (hs_falls > 0 && n - last_hs_fall != 24) bad_hs_per++;
        hs_falls++;
        last_hs_fall = n;
      end
      if (ln >= 6 && if_s.blank_n) blank_vert++;
      p_hs = if_s.HS;
      p_vs = if_s.VS;
      if (int'(dut_s.u_sync.r_h_cnt) > max_h) max_h = int'(dut_s.u_sync.r_h_cnt);
      if (int'(dut_s.u_sync.r_v_cnt) > max_v) max_v = int'(dut_s.u_sync.r_v_cnt);
    end
    check("small.model_mismatches", mism,       0);
    check("small.vs_low_total",     vs_low,     144);
    check("small.vs_fall_count",    vs_fall.size(), 3);
    if (vs_fall.size() == 3) begin
      check("small.vs_first_fall",  vs_fall[0],              193);
      check("small.frame_period_1", vs_fall[1] - vs_fall[0], 288);
      check("small.frame_period_2", vs_fall[2] - vs_fall[1], 288);
    end
    check("small.hs_fall_count",    hs_falls,   36);
    check("small.hs_period_errors", bad_hs_per, 0);
    check("small.blank_in_vblank",  blank_vert, 0);
    check("small.max_h_cnt",        max_h,      23);
    check("small.max_v_cnt",        max_v,      11);
  endtask

  initial begin
    // Line 0 of the default frame, then the first pixels of line 1.
    vecs.push_back(mk("first_px",  1,   1'b1, 1'b1, 1'b1, 24'hFFFFFF));
    vecs.push_back(mk("bar0",      41,  1'b1, 1'b1, 1'b1, 24'hFFFFFF));
    vecs.push_back(mk("bar1",      121, 1'b1, 1'b1, 1'b1, 24'hFFFF00));
    vecs.push_back(mk("bar2",      201, 1'b1, 1'b1, 1'b1, 24'h00FFFF));
    vecs.push_back(mk("bar3",      281, 1'b1, 1'b1, 1'b1, 24'h00FF00));
    vecs.push_back(mk("bar4",      361, 1'b1, 1'b1, 1'b1, 24'hFF00FF));
    vecs.push_back(mk("bar5",      441, 1'b1, 1'b1, 1'b1, 24'hFF0000));
    vecs.push_back(mk("bar6",      521, 1'b1, 1'b1, 1'b1, 24'h0000FF));
    vecs.push_back(mk("bar7",      601, 1'b1, 1'b1, 1'b1, 24'h000000));
    vecs.push_back(mk("last_act",  640, 1'b1, 1'b1, 1'b1, 24'h000000));
    vecs.push_back(mk("hblank",    641, 1'b1, 1'b1, 1'b0, 24'h000000));
    vecs.push_back(mk("pre_hs",    656, 1'b1, 1'b1, 1'b0, 24'h000000));
    vecs.push_back(mk("hs_first",  657, 1'b0, 1'b1, 1'b0, 24'h000000));
    vecs.push_back(mk("hs_last",   752, 1'b0, 1'b1, 1'b0, 24'h000000));
    vecs.push_back(mk("hs_rise",   753, 1'b1, 1'b1, 1'b0, 24'h000000));
    vecs.push_back(mk("line_end",  800, 1'b1, 1'b1, 1'b0, 24'h000000));
    vecs.push_back(mk("line1_px0", 801, 1'b1, 1'b1, 1'b1, 24'hFFFFFF));
    vecs.push_back(mk("line1_b1",  881, 1'b1, 1'b1, 1'b1, 24'hFFFF00));

    // Two-clock reset pulse on the default DUT.
    repeat (2) @(posedge clk);
    #1;
    check("rst.hs",    32'(if_d.HS),      32'd1);
    check("rst.vs",    32'(if_d.VS),      32'd1);
    check("rst.blank", 32'(if_d.blank_n), 32'd0);
    check("rst.rgb",   32'(rgb_d()),      32'd0);
    @(negedge clk);
    rst_d = 1'b0;
    clear_track();
    run_table("pass1");

    // Reach (h=300, v=1), then assert reset between clock edges.
    while (e < 1101) step_d();
    check("mid.pre.blank", 32'(if_d.blank_n), 32'd1);
    check("mid.pre.rgb",   32'(rgb_d()),      32'h00FF00);
    #2;
    rst_d = 1'b1;
    #1;
    check("mid.async.blank", 32'(if_d.blank_n), 32'd0);
    check("mid.async.rgb",   32'(rgb_d()),      32'd0);
    check("mid.async.hs",    32'(if_d.HS),      32'd1);
    check("mid.async.vs",    32'(if_d.VS),      32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_d = 1'b0;
    clear_track();
    run_table("pass2");

    run_small();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
